// File: rtl/inst_mem_loader.sv
// Instruction-memory writer: streams words into consecutive addresses from 0 and holds the CPU in reset until loaded.
// Optional LOADER_CHECKSUM_EN: one trailing checksum word must match the mod-2^16 sum of all written words.
module inst_mem_loader #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [7:0]        word_count,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

   state_t            cur, nxt;
   logic [ADDR_W-1:0] addr;
   logic              xfer;
   logic              at_end;
   logic              restart;

   assign xfer    = (cur == LOAD) && in_valid;
   assign at_end  = (addr == ADDR_W'(DEPTH - 1));
   assign restart = start && (cur == IDLE || cur == DONE || cur == ERR);
   assign state   = cur;

`ifdef LOADER_CHECKSUM_EN
   logic [15:0] sum;

   always_ff @(posedge clk) begin
      if (reset)        sum <= '0;
      else if (restart) sum <= '0;
      else if (xfer)    sum <= sum + 16'(in_data);
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) cur <= IDLE;
      else       cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      case (cur)
         IDLE:  if (start) nxt = LOAD;
         LOAD: begin
            if (in_valid) begin
`ifdef LOADER_CHECKSUM_EN
               if (in_last)     nxt = CHECK;
`else
               if (in_last)     nxt = FLUSH;
`endif
               else if (at_end) nxt = ERR;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: if (in_valid) nxt = (16'(in_data) == sum) ? FLUSH : ERR;
`else
         CHECK: nxt = IDLE;
`endif
         FLUSH: nxt = DONE;
         DONE:  if (start) nxt = LOAD;
         ERR:   if (start) nxt = LOAD;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      cpu_hold = 1'b1;
      done     = 1'b0;
      error    = 1'b0;
      case (cur)
         LOAD:  in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         CHECK: in_ready = 1'b1;
`endif
         DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
         end
         ERR:   error = 1'b1;
         default: ;
      endcase
   end

   // Write is registered: a transfer in cycle n appears on the memory port in cycle n+1.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr       <= '0;
         word_count <= '0;
         mem_wren   <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
      end else begin
         mem_wren <= xfer;
         if (restart) begin
            addr       <= '0;
            word_count <= '0;
         end else if (xfer) begin
            mem_addr   <= addr;
            mem_data   <= in_data;
            word_count <= word_count + 8'd1;
            if (!at_end) addr <= addr + ADDR_W'(1);
         end
      end
   end

endmodule
